dsp_tdm_data_controller: RTL
============================

DSP_TDM_DATA_CONTROLLER -- requirements
Module: dsp_tdm_data_controller

Interface
REQ-001 SHALL have parameter NUM_CASCADE_CHAINS, default 32, meaning number of DSP cascade chains (lanes).
REQ-002 SHALL have parameter MUX_FACTOR, default 2, range 1..4, meaning time-multiplex slots per accepted input word.
REQ-003 SHALL have parameter DATA_W, default 16, meaning operand width.
REQ-004 SHALL have parameter ACC_W, default 40, meaning DSP result width.
REQ-005 SHALL have parameter IN_DELAY, default 4, range 0..8, meaning operand alignment pipeline stages after the mux.
REQ-006 SHALL have port clk  input  1  meaning DSP clock, the only clock.
REQ-007 SHALL have port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-008 SHALL have ports A_data and B_data  input  MUX_FACTOR x NUM_CASCADE_CHAINS x DATA_W  meaning operand slots, indexed [slot][lane].
REQ-009 SHALL have ports in_valid  input  1  and in_ready  output  1  meaning input word handshake.
REQ-010 SHALL have ports DSP_A_data and DSP_B_data  output  NUM_CASCADE_CHAINS x DATA_W  meaning one slot per cycle to the GEMM array.
REQ-011 SHALL have port DSP_data_valid  output  1  meaning DSP_A_data and DSP_B_data valid.
REQ-012 SHALL have ports dsp_op  input  NUM_CASCADE_CHAINS x ACC_W  and dsp_op_valid  input  1  meaning GEMM results.
REQ-013 SHALL have port flush  input  1  meaning discard the partially collected output word.
REQ-014 SHALL have ports out_data  output  MUX_FACTOR*NUM_CASCADE_CHAINS x ACC_W  and out_valid  output  1  meaning gathered result word.
REQ-015 SHALL have port partial  output  1  meaning output collection in progress (beat count != 0).

Function
REQ-016 Input phase counter SHALL count 0..MUX_FACTOR-1; in_ready SHALL equal (phase == 0) and SHALL be driven from a register.
REQ-017 On in_valid & in_ready, all slots SHALL be captured; the counter SHALL step once per cycle until it wraps to 0; in_valid while in_ready = 0 SHALL be ignored.
REQ-018 Slot k of a word accepted at cycle t SHALL appear on DSP_A_data/DSP_B_data with DSP_data_valid = 1 at cycle t+1+IN_DELAY+k.
REQ-019 With continuous in_valid, words SHALL be accepted every MUX_FACTOR cycles, and DSP_data_valid SHALL stay high without gaps.
REQ-020 When no slot is active, DSP_data_valid SHALL be 0 and the DSP data outputs SHALL be 0.
REQ-021 The output beat counter SHALL advance only on dsp_op_valid; gaps between beats are legal.
REQ-022 The beat-k result for lane i SHALL be stored at out_data index k*NUM_CASCADE_CHAINS+i.
REQ-023 out_valid SHALL pulse for 1 cycle, in the cycle after the MUX_FACTOR-th beat; out_data SHALL hold its value until the next out_valid.
REQ-024 On flush, the beat counter SHALL clear; flush together with dsp_op_valid SHALL drop that beat; flush SHALL NOT affect the input side.
REQ-025 MUX_FACTOR = 1 SHALL give in_ready = 1 constantly after reset, data delayed by 1+IN_DELAY cycles, and out_valid one cycle after each dsp_op_valid.

Reset
REQ-026 While rst_n = 0 at a clk edge, all of the following SHALL clear to 0: in_ready, DSP data and valid outputs, out_data, out_valid, partial, phase counter, beat counter, and the delay pipeline.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.
REQ-028 Reset mid-operation SHALL abandon in-flight slots and partial words, with no valid pulse after release.

Structure
REQ-029 A shared package SHALL hold slot-index and beat-count width functions, the operand and result lane typedefs, and the MUX_FACTOR/IN_DELAY legal-range constants.
REQ-030 The operand alignment pipeline SHALL be a sub-module dsp_delay_line, parametrised in width and depth, where depth 0 is a wire.

Verification
REQ-031 Defaults, one word with A slot0 lane0 = 0x0001 and slot1 lane0 = 0x0002, accepted at cycle 10 -> DSP_A_data[0] = 0x0001 at cycle 15 and 0x0002 at cycle 16, valid for exactly 2 cycles.
REQ-032 in_valid held high for 8 cycles -> 4 words accepted, in_ready pattern 1010..., DSP_data_valid high for 8 consecutive cycles.
REQ-033 dsp_op_valid beats with lane0 = 0x10 then, after a 3-cycle gap, 0x20 -> one out_valid pulse with out_data[0] = 0x10 and out_data[32] = 0x20.
REQ-034 One beat, then flush together with the next beat, then 2 beats -> a single out_valid carrying only the last two beats; partial = 0 after the flush.
REQ-035 rst_n = 0 for 1 cycle between slot0 and slot1 of a word -> no further DSP_data_valid, all outputs 0, in_ready = 1 in the next cycle.
REQ-036 MUX_FACTOR = 4, IN_DELAY = 0 -> in_ready high 1 cycle in 4; slots 0..3 at t+1..t+4; out_valid after every 4th beat.

Source files
------------

// File: rtl/dsp_tdm_data_controller_pkg.sv
// Shared definitions for the DSP TDM data controller.
// Holds the legal parameter ranges, default lane typedefs and the
// width helpers used to size the slot-phase and beat counters.
package dsp_tdm_data_controller_pkg;

    localparam int unsigned MUX_FACTOR_MIN = 1;
    localparam int unsigned MUX_FACTOR_MAX = 4;
    localparam int unsigned IN_DELAY_MIN   = 0;
    localparam int unsigned IN_DELAY_MAX   = 8;

    localparam int unsigned LANE_DATA_W = 16;
    localparam int unsigned LANE_ACC_W  = 40;

    typedef logic [LANE_DATA_W-1:0] operand_lane_t;
    typedef logic [LANE_ACC_W-1:0]  result_lane_t;

    // Width of the input slot-phase counter (at least 1 bit).
    function automatic int unsigned slot_idx_w(input int unsigned mux);
        return (mux > 1) ? $clog2(mux) : 1;
    endfunction

    // Width of the output beat counter (at least 1 bit).
    function automatic int unsigned beat_cnt_w(input int unsigned mux);
        return (mux > 1) ? $clog2(mux) : 1;
    endfunction

endpackage

// File: rtl/dsp_tdm_data_controller_delay_line.sv
// dsp_delay_line: resettable shift pipeline of DEPTH stages, WIDTH bits.
// Ports: clk, rst_n (sync, active-low), d_i (input word), q_o (d_i delayed
// by DEPTH cycles). DEPTH = 0 degenerates to a plain wire.
module dsp_delay_line
    import dsp_tdm_data_controller_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int unsigned s = 1; s < DEPTH; s++) begin
                    stage_q[s] <= stage_q[s-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/dsp_tdm_data_controller.sv
// DSP TDM data controller.
// Input side: accepts a word of MUX_FACTOR operand slots (A_data/B_data,
// [slot][lane]) on in_valid & in_ready, then serialises one slot per cycle
// through an IN_DELAY-stage alignment pipeline onto DSP_A_data/DSP_B_data
// with DSP_data_valid.
// Output side: gathers MUX_FACTOR GEMM result beats (dsp_op on dsp_op_valid)
// into out_data (beat k, lane i at index k*NUM_CASCADE_CHAINS+i), pulsing
// out_valid once per complete word. flush discards a partial word; partial
// flags that collection is in progress.
module dsp_tdm_data_controller
    import dsp_tdm_data_controller_pkg::*;
#(
    parameter int unsigned NUM_CASCADE_CHAINS = 32,
    parameter int unsigned MUX_FACTOR         = 2,
    parameter int unsigned DATA_W             = 16,
    parameter int unsigned ACC_W              = 40,
    parameter int unsigned IN_DELAY           = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic [MUX_FACTOR-1:0][NUM_CASCADE_CHAINS-1:0][DATA_W-1:0] A_data,
    input  logic [MUX_FACTOR-1:0][NUM_CASCADE_CHAINS-1:0][DATA_W-1:0] B_data,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    output logic [NUM_CASCADE_CHAINS-1:0][DATA_W-1:0]            DSP_A_data,
    output logic [NUM_CASCADE_CHAINS-1:0][DATA_W-1:0]            DSP_B_data,
    output logic                                                 DSP_data_valid,
    input  logic [NUM_CASCADE_CHAINS-1:0][ACC_W-1:0]             dsp_op,
    input  logic                                                 dsp_op_valid,
    input  logic                                                 flush,
    output logic [MUX_FACTOR*NUM_CASCADE_CHAINS-1:0][ACC_W-1:0]  out_data,
    output logic                                                 out_valid,
    output logic                                                 partial
);

    localparam int unsigned N      = NUM_CASCADE_CHAINS;
    localparam int unsigned SLOT_W = slot_idx_w(MUX_FACTOR);
    localparam int unsigned BEAT_W = beat_cnt_w(MUX_FACTOR);
    localparam int unsigned PIPE_W = 1 + 2 * N * DATA_W;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MUX_FACTOR - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MUX_FACTOR - 1);

    // ---------------- input side ----------------
    logic [SLOT_W-1:0] phase_q, phase_d;
    logic              in_ready_q;
    logic              accept;
    logic [MUX_FACTOR-1:0][N-1:0][DATA_W-1:0] hold_a_q, hold_b_q;
    logic [N-1:0][DATA_W-1:0] mux_a_q, mux_a_d, mux_b_q, mux_b_d;
    logic                     mux_v_q, mux_v_d;
    logic [PIPE_W-1:0]        pipe_in, pipe_out;

    assign accept = in_valid & in_ready_q;

    // Slot 0 goes straight from the ports into the mux register on accept;
    // later slots are replayed from the holding register, one per cycle.
    always_comb begin
        phase_d = phase_q;
        mux_v_d = 1'b0;
        mux_a_d = '0;
        mux_b_d = '0;
        if (accept) begin
            mux_v_d = 1'b1;
            mux_a_d = A_data[0];
            mux_b_d = B_data[0];
            phase_d = (LAST_SLOT == '0) ? '0 : SLOT_W'(1);
        end else if (phase_q != '0) begin
            mux_v_d = 1'b1;
            for (int unsigned k = 0; k < MUX_FACTOR; k++) begin
                if (phase_q == SLOT_W'(k)) begin
                    mux_a_d = hold_a_q[k];
                    mux_b_d = hold_b_q[k];
                end
            end
            phase_d = (phase_q == LAST_SLOT) ? '0 : phase_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q    <= '0;
            in_ready_q <= 1'b0;
            mux_v_q    <= 1'b0;
            mux_a_q    <= '0;
            mux_b_q    <= '0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
        end else begin
            phase_q    <= phase_d;
            in_ready_q <= (phase_d == '0);
            mux_v_q    <= mux_v_d;
            mux_a_q    <= mux_a_d;
            mux_b_q    <= mux_b_d;
            if (accept) begin
                hold_a_q <= A_data;
                hold_b_q <= B_data;
            end
        end
    end

    assign pipe_in = {mux_v_q, mux_a_q, mux_b_q};

    dsp_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (IN_DELAY)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pipe_in),
        .q_o   (pipe_out)
    );

    assign {DSP_data_valid, DSP_A_data, DSP_B_data} = pipe_out;
    assign in_ready = in_ready_q;

    // ---------------- output side ----------------
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [MUX_FACTOR*N-1:0][ACC_W-1:0] coll_q, coll_d, out_data_q;
    logic out_valid_q;
    logic last_beat;

    always_comb begin
        beat_d    = beat_q;
        coll_d    = coll_q;
        last_beat = 1'b0;
        if (flush) begin
            beat_d = '0;
        end else if (dsp_op_valid) begin
            for (int unsigned k = 0; k < MUX_FACTOR; k++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (beat_q == BEAT_W'(k)) begin
                        coll_d[k*N+i] = dsp_op[i];
                    end
                end
            end
            if (beat_q == LAST_BEAT) begin
                beat_d    = '0;
                last_beat = 1'b1;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q      <= '0;
            coll_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            coll_q      <= coll_d;
            out_valid_q <= last_beat;
            if (last_beat) begin
                out_data_q <= coll_d;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign partial   = (beat_q != '0);

endmodule
